// File: rtl/stack_pkg.sv
// Shared types and default widths for the return-address stack and its controller.
package stack_pkg;

    localparam int ADDR_WIDTH_DEF = 8;
    localparam int DEPTH_DEF      = 8;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_PUSH,
        OP_POP,
        OP_REPLACE
    } stack_op_t;

    // Push+pop on an empty stack degrades to a plain push; illegal requests become NOP.
    function automatic stack_op_t decode_op(
        input logic push,
        input logic pop,
        input logic empty,
        input logic full
    );
        stack_op_t op;
        op = OP_NOP;
        if (push && pop) begin
            op = empty ? OP_PUSH : OP_REPLACE;
        end else if (push) begin
            op = full ? OP_NOP : OP_PUSH;
        end else if (pop) begin
            op = empty ? OP_NOP : OP_POP;
        end
        return op;
    endfunction

    function automatic logic is_overflow(input logic push, input logic pop, input logic full);
        return push && !pop && full;
    endfunction

    function automatic logic is_underflow(input logic push, input logic pop, input logic empty);
        return pop && !push && empty;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Entry storage for call_stack: one synchronous write port, one combinational read port, no reset.
module stack_mem #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [PTR_W-1:0]      waddr,
    input  logic [ADDR_WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0]      raddr,
    output logic [ADDR_WIDTH-1:0] rdata
);

    logic [ADDR_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack.sv
// Return-address stack: pointer, op decode, registered top-of-stack and sticky error flag.
// Optional error reporting is built only when CALL_STACK_ERR_EN is defined.
module call_stack
    import stack_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_WIDTH-1:0]        push_data,
    output logic [ADDR_WIDTH-1:0]        top,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         err
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = $clog2(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;

    logic [CNT_W-1:0]      sp_p1;
    logic [ADDR_WIDTH-1:0] top_p1;
    stack_op_t             op_p0;
    logic                  mem_we_p0;
    ptr_t                  mem_waddr_p0;
    ptr_t                  mem_raddr_p0;
    logic [ADDR_WIDTH-1:0] mem_rdata_p0;

    assign empty = (sp_p1 == '0);
    assign full  = (sp_p1 == CNT_W'(DEPTH));
    assign count = sp_p1;
    assign top   = top_p1;

    // Stage p0: request decode and memory addressing
    always_comb begin
        op_p0        = decode_op(push, pop, empty, full);
        mem_we_p0    = 1'b0;
        mem_waddr_p0 = ptr_t'(sp_p1);
        mem_raddr_p0 = ptr_t'(sp_p1) - ptr_t'(2);
        unique case (op_p0)
            OP_PUSH: begin
                mem_we_p0    = 1'b1;
                mem_waddr_p0 = ptr_t'(sp_p1);
            end
            OP_REPLACE: begin
                mem_we_p0    = 1'b1;
                mem_waddr_p0 = ptr_t'(sp_p1) - ptr_t'(1);
            end
            default: begin
                mem_we_p0    = 1'b0;
            end
        endcase
    end

    stack_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_stack_mem (
        .clk   (clk),
        .we    (mem_we_p0),
        .waddr (mem_waddr_p0),
        .wdata (push_data),
        .raddr (mem_raddr_p0),
        .rdata (mem_rdata_p0)
    );

    // Stage p1: pointer and top-of-stack registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_p1  <= '0;
            top_p1 <= '0;
        end else begin
            unique case (op_p0)
                OP_PUSH: begin
                    sp_p1  <= sp_p1 + CNT_W'(1);
                    top_p1 <= push_data;
                end
                OP_POP: begin
                    sp_p1  <= sp_p1 - CNT_W'(1);
                    top_p1 <= (sp_p1 == CNT_W'(1)) ? '0 : mem_rdata_p0;
                end
                OP_REPLACE: begin
                    top_p1 <= push_data;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CALL_STACK_ERR_EN
    logic err_p1;
    logic err_det_p0;

    assign err_det_p0 = is_overflow(push, pop, full) || is_underflow(push, pop, empty);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_p1 <= 1'b0;
        end else if (err_det_p0) begin
            err_p1 <= 1'b1;
        end
    end

    assign err = err_p1;
`else
    assign err = 1'b0;
`endif

endmodule
